mix_signmag_adder: RTL and testbench
====================================

Name: mix_signmag_adder

Overview:
- Sign-magnitude arithmetic block for the MIX CPU datapath.
- Registered 31-bit word adder (rA-style ADD) with start/done handshake and overflow flag.
- Combinational 31-bit decrement path (in1 − in2, used by DEC/compare-style ops).
- Combinational 13-bit index-register adder (rI-style: 1 sign bit + 12-bit magnitude).

Parameters:
- WMAG, 30, word magnitude width; word = {sign, WMAG bits}.
- IMAG, 12, index magnitude width; index = {sign, IMAG bits}.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; samples in1/in2 into the word adder.
- in1  input  31  word operand 1; bit30 = sign (1 = negative), bits29:0 = magnitude.
- in2  input  31  word operand 2, same format.
- sum  output  31  registered in1 + in2.
- sum_ovf  output  1  registered overflow for sum.
- done  output  1  one-cycle pulse when sum/sum_ovf are updated.
- diff  output  31  combinational in1 − in2.
- diff_ovf  output  1  combinational overflow for diff.
- a  input  13  index operand a; bit12 = sign, bits11:0 = magnitude.
- b  input  13  index operand b.
- isum  output  13  combinational a + b.
- isum_ovf  output  1  combinational magnitude carry-out for isum.

Behaviour:
- Sign-magnitude add core, shared rule for all three paths (X + Y):
  - Equal signs: magnitude = |X| + |Y|; sign = common sign; overflow = carry out of the MSB; stored magnitude = low bits (mod 2^WMAG or 2^IMAG).
  - Different signs: subtract the smaller magnitude from the larger; sign = sign of the larger-magnitude operand; overflow = 0.
  - Different signs with equal magnitudes: result magnitude 0, sign = sign of X (first operand). −0 and +0 are distinct results.
- diff = in1 + (in2 with sign inverted), using the core rule; a zero result takes in1's sign.
- Word path timing: on a rising clk with start = 1, sum and sum_ovf load the core result for in1/in2; done = 1 for that cycle only.
  - Latency is 1 cycle; a new start may be issued every cycle.
  - With start = 0, sum and sum_ovf hold and done = 0.
- diff, diff_ovf, isum and isum_ovf are purely combinational. They do not depend on start and are unaffected by reset.
- Reset (asynchronous, any time, including the cycle of a start): sum = +0 (31'd0), sum_ovf = 0, done = 0. A start that coincides with reset is discarded.

Optional Feature:
- Macro: MIX_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit).
  - When start = 1 and sub = 1, the registered path computes in1 − in2 (same rules as diff) into sum/sum_ovf.
  - When sub = 0, the registered path adds, as above.
- Undefined: no sub port; the registered path always adds.

Test Plan:
- in1 = +123, in2 = +123, start pulse → next cycle sum = +246, sum_ovf = 0, done pulse. Same cycle: diff = +0. With a = +16, b = +3 → isum = +19.
- in1 = +123, in2 = −123 → sum = +0. diff = +246. With a = −16, b = +3 → isum = −13.
- in1 = −123, in2 = +123 → sum = −0 (sign 1). diff = −246. With a = +16, b = −3 → isum = +13.
- in1 = −123, in2 = −123 → sum = −246. diff = −0. With a = −16, b = −3 → isum = −19.
- in1 = +0o7777777777, in2 = +1 → sum = +0, sum_ovf = 1, diff = +0o7777777776. With a = −3, b = +3 → isum = −0; with a = +3, b = −3 → isum = +0. a = +4095, b = +1 → isum = +0, isum_ovf = 1.
- Assert reset during a start cycle → sum = 0, sum_ovf = 0, done = 0 immediately. After release, start with +5/+7 → sum = +12.

Source files
------------

// File: rtl/mix_signmag_adder.sv
// mix_signmag_adder: sign-magnitude arithmetic for the MIX datapath.
//   - registered word adder (sum/sum_ovf) with start/done handshake
//   - combinational word difference (diff/diff_ovf)
//   - combinational index-register adder (isum/isum_ovf)
// Optional feature macro: MIX_ADDER_SUB_EN adds a 'sub' input so the
// registered path can compute in1 - in2 instead of in1 + in2.

// Sign-magnitude add core: X + Y, where a zero result from unlike signs
// keeps X's sign, so -0 and +0 stay distinct.
module mix_sm_core #(
  parameter int MAG = 30
) (
  input  logic           i_x_sign,
  input  logic [MAG-1:0] i_x_mag,
  input  logic           i_y_sign,
  input  logic [MAG-1:0] i_y_mag,
  output logic           o_sign,
  output logic [MAG-1:0] o_mag,
  output logic           o_ovf
);

  logic [MAG:0] w_mag_sum;

  assign w_mag_sum = {1'b0, i_x_mag} + {1'b0, i_y_mag};

  // Like signs add magnitudes; unlike signs subtract the smaller from the larger.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_sign = i_x_sign;
    o_mag  = '0;
    o_ovf  = 1'b0;
    if (i_x_sign == i_y_sign) begin
      o_mag = w_mag_sum[MAG-1:0];
      o_ovf = w_mag_sum[MAG];
    end else if (i_x_mag >= i_y_mag) begin
      // Equal magnitudes land here too, giving a zero carrying X's sign.
      o_mag = i_x_mag - i_y_mag;
    end else begin
      o_sign = i_y_sign;
      o_mag  = i_y_mag - i_x_mag;
    end
  end

endmodule

module mix_signmag_adder #(
  parameter int WMAG = 30,
  parameter int IMAG = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
`ifdef MIX_ADDER_SUB_EN
  input  logic          sub,
`endif
  input  logic [WMAG:0] in1,
  input  logic [WMAG:0] in2,
  output logic [WMAG:0] sum,
  output logic          sum_ovf,
  output logic          done,
  output logic [WMAG:0] diff,
  output logic          diff_ovf,
  input  logic [IMAG:0] a,
  input  logic [IMAG:0] b,
  output logic [IMAG:0] isum,
  output logic          isum_ovf
);

  logic            w_add_y_sign;
  logic            w_add_sign;
  logic [WMAG-1:0] w_add_mag;
  logic            w_add_ovf;

  logic [WMAG:0]   r_sum;
  logic            r_sum_ovf;
  logic            r_done;

  // The registered path negates in2 by flipping its sign when subtracting.
`ifdef MIX_ADDER_SUB_EN
  assign w_add_y_sign = in2[WMAG] ^ sub;
`else
  assign w_add_y_sign = in2[WMAG];
`endif

  mix_sm_core #(.MAG(WMAG)) u_word_add (
    .i_x_sign (in1[WMAG]),
    .i_x_mag  (in1[WMAG-1:0]),
    .i_y_sign (w_add_y_sign),
    .i_y_mag  (in2[WMAG-1:0]),
    .o_sign   (w_add_sign),
    .o_mag    (w_add_mag),
    .o_ovf    (w_add_ovf)
  );

  // diff = in1 + (-in2); a zero result inherits in1's sign from the core.
  mix_sm_core #(.MAG(WMAG)) u_word_diff (
    .i_x_sign (in1[WMAG]),
    .i_x_mag  (in1[WMAG-1:0]),
    .i_y_sign (~in2[WMAG]),
    .i_y_mag  (in2[WMAG-1:0]),
    .o_sign   (diff[WMAG]),
    .o_mag    (diff[WMAG-1:0]),
    .o_ovf    (diff_ovf)
  );

  mix_sm_core #(.MAG(IMAG)) u_index_add (
    .i_x_sign (a[IMAG]),
    .i_x_mag  (a[IMAG-1:0]),
    .i_y_sign (b[IMAG]),
    .i_y_mag  (b[IMAG-1:0]),
    .o_sign   (isum[IMAG]),
    .o_mag    (isum[IMAG-1:0]),
    .o_ovf    (isum_ovf)
  );

  // Load the word result on start and pulse done for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum     <= '0;
      r_sum_ovf <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_done <= start;
      if (start) begin
        r_sum     <= {w_add_sign, w_add_mag};
        r_sum_ovf <= w_add_ovf;
      end
    end
  end

  assign sum     = r_sum;
  assign sum_ovf = r_sum_ovf;
  assign done    = r_done;

endmodule

// File: tb/tb_mix_signmag_adder.sv
// Testbench for mix_signmag_adder: directed cases with hand-derived
// constants plus random traffic scored against a signed-integer model.
module tb_mix_signmag_adder;

  localparam int WMAG = 30;
  localparam int IMAG = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          tb_sub;
  logic [WMAG:0] in1, in2;
  logic [WMAG:0] sum, diff;
  logic          sum_ovf, done, diff_ovf;
  logic [IMAG:0] a, b, isum;
  logic          isum_ovf;

  int n_vec = 0;
  int n_err = 0;

  // Expected {ovf, sum} entries, pushed at start and popped on done.
  logic [WMAG+1:0] sb_q[$];

  mix_signmag_adder #(.WMAG(WMAG), .IMAG(IMAG)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef MIX_ADDER_SUB_EN
    .sub      (tb_sub),
`endif
    .in1      (in1),
    .in2      (in2),
    .sum      (sum),
    .sum_ovf  (sum_ovf),
    .done     (done),
    .diff     (diff),
    .diff_ovf (diff_ovf),
    .a        (a),
    .b        (b),
    .isum     (isum),
    .isum_ovf (isum_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: convert to signed integers, add, convert back.
  function automatic void sm_model(input int mw, input logic xs, input longint xm,
                                   input logic ys, input longint ym,
                                   output logic rs, output longint rm, output logic ro);
    longint sx, sy, s, mag;
    sx  = xs ? -xm : xm;
    sy  = ys ? -ym : ym;
    s   = sx + sy;
    rs  = (s == 0) ? xs : (s < 0);
    mag = (s < 0) ? -s : s;
    ro  = mag >= (longint'(1) << mw);
    rm  = mag % (longint'(1) << mw);
  endfunction

  function automatic logic [WMAG+1:0] word_model(input logic [WMAG:0] x, input logic [WMAG:0] y);
    logic rs, ro;
    longint rm;
    sm_model(WMAG, x[WMAG], longint'(x[WMAG-1:0]), y[WMAG], longint'(y[WMAG-1:0]), rs, rm, ro);
    return {ro, rs, rm[WMAG-1:0]};
  endfunction

  function automatic logic [IMAG+1:0] idx_model(input logic [IMAG:0] x, input logic [IMAG:0] y);
    logic rs, ro;
    longint rm;
    sm_model(IMAG, x[IMAG], longint'(x[IMAG-1:0]), y[IMAG], longint'(y[IMAG-1:0]), rs, rm, ro);
    return {ro, rs, rm[IMAG-1:0]};
  endfunction

  // Score the registered path one step after each rising edge.
  initial begin
    logic [WMAG+1:0] exp_w;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (sb_q.size() == 0) begin
          check("done_unexpected", 64'(done), 64'd0);
        end else begin
          exp_w = sb_q.pop_front();
          check("sum", 64'(sum), 64'(exp_w[WMAG:0]));
          check("sum_ovf", 64'(sum_ovf), 64'(exp_w[WMAG+1]));
        end
      end
    end
  end

  // Drive one start with model-derived expectations; combinational paths checked too.
  task automatic issue(input logic [WMAG:0] x, input logic [WMAG:0] y,
                       input logic [IMAG:0] ia, input logic [IMAG:0] ib, input logic s);
    logic [WMAG+1:0] exp_d;
    logic [IMAG+1:0] exp_i;
    @(negedge clk);
    in1 = x; in2 = y; a = ia; b = ib; tb_sub = s; start = 1'b1;
    sb_q.push_back(word_model(x, {y[WMAG] ^ s, y[WMAG-1:0]}));
    exp_d = word_model(x, {~y[WMAG], y[WMAG-1:0]});
    exp_i = idx_model(ia, ib);
    #1;
    check("diff", 64'({diff_ovf, diff}), 64'(exp_d));
    check("isum", 64'({isum_ovf, isum}), 64'(exp_i));
  endtask

  typedef struct {
    logic [WMAG:0] x, y, s;
    logic          s_ovf;
    logic [WMAG:0] d;
    logic          d_ovf;
    logic [IMAG:0] ia, ib, is;
    logic          i_ovf;
  } dvec_t;

  function automatic logic [WMAG:0] w(input logic sg, input int unsigned m);
    return {sg, 30'(m)};
  endfunction

  function automatic logic [IMAG:0] ix(input logic sg, input int unsigned m);
    return {sg, 12'(m)};
  endfunction

  dvec_t dv[7];

  initial begin
    logic [WMAG:0] last_sum;
    logic [WMAG:0] rx, ry;
    logic [IMAG:0] ra, rb;

    dv[0] = '{w(0,123), w(0,123), w(0,246), 0, w(0,0),   0, ix(0,16), ix(0,3), ix(0,19), 0};
    dv[1] = '{w(0,123), w(1,123), w(0,0),   0, w(0,246), 0, ix(1,16), ix(0,3), ix(1,13), 0};
    dv[2] = '{w(1,123), w(0,123), w(1,0),   0, w(1,246), 0, ix(0,16), ix(1,3), ix(0,13), 0};
    dv[3] = '{w(1,123), w(1,123), w(1,246), 0, w(1,0),   0, ix(1,16), ix(1,3), ix(1,19), 0};
    dv[4] = '{w(0,30'h3FFF_FFFF), w(0,1), w(0,0), 1, w(0,30'h3FFF_FFFE), 0,
              ix(1,3), ix(0,3), ix(1,0), 0};
    dv[5] = '{w(0,5), w(0,7), w(0,12), 0, w(1,2), 0, ix(0,3), ix(1,3), ix(0,0), 0};
    dv[6] = '{w(0,30'h2000_0000), w(0,30'h2000_0000), w(0,0), 1, w(0,0), 0,
              ix(0,4095), ix(0,1), ix(0,0), 1};

    reset = 1'b1; start = 1'b0; tb_sub = 1'b0;
    in1 = '0; in2 = '0; a = '0; b = '0;
    #1;
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_ovf", 64'(sum_ovf), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed cases, issued back to back.
    foreach (dv[i]) begin
      @(negedge clk);
      in1 = dv[i].x; in2 = dv[i].y; a = dv[i].ia; b = dv[i].ib; tb_sub = 1'b0; start = 1'b1;
      sb_q.push_back({dv[i].s_ovf, dv[i].s});
      #1;
      check($sformatf("dir%0d_diff", i), 64'({diff_ovf, diff}), 64'({dv[i].d_ovf, dv[i].d}));
      check($sformatf("dir%0d_isum", i), 64'({isum_ovf, isum}), 64'({dv[i].i_ovf, dv[i].is}));
      last_sum = dv[i].s;
    end
    @(negedge clk);
    start = 1'b0;
    in1 = w(0,99); in2 = w(0,1);
    @(negedge clk);
    check("hold_sum", 64'(sum), 64'(last_sum));
    check("hold_done", 64'(done), 64'd0);

    // Reset asserted during a start with nonzero state loaded.
    issue(w(1,1000), w(1,1), ix(0,0), ix(0,0), 1'b0);
    @(negedge clk);
    in1 = w(0,77); in2 = w(0,66); start = 1'b1; reset = 1'b1;
    #1;
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_ovf", 64'(sum_ovf), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    check("rst_discard", 64'({sum_ovf, done, sum}), 64'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    in1 = w(0,5); in2 = w(0,7); start = 1'b1;
    sb_q.push_back({1'b0, w(0,12)});
    @(negedge clk);
    start = 1'b0;

    // Random traffic biased towards boundary magnitudes.
    for (int n = 0; n < 300; n++) begin
      rx = {1'($urandom), 30'($urandom)};
      ry = {1'($urandom), 30'($urandom)};
      ra = {1'($urandom), 12'($urandom)};
      rb = {1'($urandom), 12'($urandom)};
      case ($urandom_range(3))
        0: begin ry[WMAG-1:0] = rx[WMAG-1:0]; rb[IMAG-1:0] = ra[IMAG-1:0]; end
        1: begin rx[WMAG-1:0] = '1; rb[IMAG-1:0] = '1; end
        2: begin ry[WMAG-1:0] = '0; ra[IMAG-1:0] = '0; end
        default: ;
      endcase
`ifdef MIX_ADDER_SUB_EN
      issue(rx, ry, ra, rb, 1'($urandom));
`else
      issue(rx, ry, ra, rb, 1'b0);
`endif
      if ($urandom_range(3) == 0) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
